// File: rtl/regfile_write_sequencer.sv
// Writeback sequencer: decodes dstE/dstM for a Y86-64 instruction and
// serialises the two register-file writes (E then M) through one write port.
module regfile_write_sequencer #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4,
  parameter int RSP_ID = 4,
  parameter int RNONE  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              wb_done,
  output logic              halted,
  output logic              instr_err
);

  localparam logic [ADDR_W-1:0] NONE_IDX = ADDR_W'(RNONE);
  localparam logic [ADDR_W-1:0] RSP_IDX  = ADDR_W'(RSP_ID);

  typedef enum logic [1:0] {IDLE, WR_E, WR_M, HALT} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] dst_e, dst_m, dec_e, dec_m;
  logic [DATA_W-1:0] val_e, val_m;
  logic              done_flag, err_flag;
  logic              accept, is_halt;

  // Function code is carried with the request but cnd already encodes it.
  logic unused_ifun;
  assign unused_ifun = ^ifun;

  assign accept  = wb_valid && (state == IDLE);
  assign is_halt = (icode == 4'd0) || (icode > 4'd11);

  always_comb begin
    dec_e = NONE_IDX;
    dec_m = NONE_IDX;
    case (icode)
      4'd2:             dec_e = cnd ? ADDR_W'(rB) : NONE_IDX;
      4'd3, 4'd6:       dec_e = ADDR_W'(rB);
      4'd8, 4'd9, 4'd10: dec_e = RSP_IDX;
      4'd5:             dec_m = ADDR_W'(rA);
      4'd11: begin
        dec_e = RSP_IDX;
        dec_m = ADDR_W'(rA);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      dst_e     <= NONE_IDX;
      dst_m     <= NONE_IDX;
      val_e     <= '0;
      val_m     <= '0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
    end else begin
      state <= state_next;
      // Retirements that never reach a write state report done one cycle after accept.
      done_flag <= accept && (is_halt || ((dec_e == NONE_IDX) && (dec_m == NONE_IDX)));
      if (accept) begin
        dst_e <= dec_e;
        dst_m <= dec_m;
        val_e <= valE;
        val_m <= valM;
        if (icode > 4'd11) err_flag <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_halt)                state_next = HALT;
          else if (dec_e != NONE_IDX) state_next = WR_E;
          else if (dec_m != NONE_IDX) state_next = WR_M;
        end
      end
      WR_E:    state_next = (dst_m != NONE_IDX) ? WR_M : IDLE;
      WR_M:    state_next = IDLE;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    wb_done  = done_flag;
    wb_ready = (state == IDLE);
    halted   = (state == HALT);
    instr_err = err_flag;
    case (state)
      WR_E: begin
        rf_we    = 1'b1;
        rf_waddr = dst_e;
        rf_wdata = val_e;
        wb_done  = (dst_m == NONE_IDX);
      end
      WR_M: begin
        rf_we    = 1'b1;
        rf_waddr = dst_m;
        rf_wdata = val_m;
        wb_done  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
